// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// The ARB_TIMEOUT_EN build option enables the transaction watchdog.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    localparam logic [31:0] DEAD_WORD       = 32'hDEAD_BEEF;
    localparam int          TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Wait-cycle counter for an outstanding RAM transaction; flags expiry on the
// TIMEOUT-th cycle without an ack. Only instantiated when ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i & (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's fetch and data ports onto one single-port RAM using a
// registered req/ack handshake. Define ARB_TIMEOUT_EN to add the ack watchdog.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_ren,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_data,
    output logic              inst_stall,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] mem_din,
    output logic              data_stall,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic              arb_err
);

    arb_state_e        state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic              ram_req_q, ram_req_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] inst_data_q, inst_data_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;

    logic              i_pend, d_pend;
    logic              grant_i, grant_d;
    logic              in_gnt, abort, xfer_end;
    logic [DATA_W-1:0] rd_word;

    // A port whose done flag is high this cycle has just been serviced.
    assign i_pend  = inst_ren & ~i_done_q;
    assign d_pend  = (mem_ren | mem_wen) & ~d_done_q;
    assign grant_d = (state_q == IDLE) & d_pend & (~i_pend | (last_grant_q == GRANT_I));
    assign grant_i = (state_q == IDLE) & i_pend & ~grant_d;

    assign in_gnt   = (state_q == GNT_I) | (state_q == GNT_D);
    assign xfer_end = in_gnt & (ram_ack | abort);

`ifdef ARB_TIMEOUT_EN
    logic wd_expired;
    logic arb_err_q;

    mem_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (grant_i | grant_d),
        .run_i    (in_gnt),
        .expired_o(wd_expired)
    );

    // A real ack arriving on the expiry cycle still wins over the abort.
    assign abort   = wd_expired & ~ram_ack;
    assign rd_word = abort ? DATA_W'(DEAD_WORD) : ram_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arb_err_q <= 1'b0;
        end else begin
            arb_err_q <= arb_err_q | abort;
        end
    end

    assign arb_err = arb_err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^8'(TIMEOUT);
    assign abort          = 1'b0;
    assign rd_word        = ram_rdata;
    assign arb_err        = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = GNT_D;
                end else if (grant_i) begin
                    state_d = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (xfer_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        ram_req_d    = ram_req_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        inst_data_d  = inst_data_q;
        mem_din_d    = mem_din_q;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;

        if (grant_d) begin
            last_grant_d = GRANT_D;
            ram_req_d    = 1'b1;
            ram_we_d     = mem_wen;
            ram_addr_d   = mem_addr;
            ram_wdata_d  = mem_dout;
        end else if (grant_i) begin
            last_grant_d = GRANT_I;
            ram_req_d    = 1'b1;
            ram_we_d     = 1'b0;
            ram_addr_d   = inst_addr;
        end

        if (xfer_end) begin
            ram_req_d = 1'b0;
            ram_we_d  = 1'b0;
            if (state_q == GNT_I) begin
                i_done_d    = 1'b1;
                inst_data_d = rd_word;
            end else begin
                d_done_d = 1'b1;
                if (!ram_we_q) begin
                    mem_din_d = rd_word;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= GRANT_I;
            ram_req_q    <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            inst_data_q  <= '0;
            mem_din_q    <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            ram_req_q    <= ram_req_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            inst_data_q  <= inst_data_d;
            mem_din_q    <= mem_din_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
        end
    end

    assign ram_req    = ram_req_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign inst_data  = inst_data_q;
    assign mem_din    = mem_din_q;
    assign inst_stall = inst_ren & ~i_done_q;
    assign data_stall = (mem_ren | mem_wen) & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the watchdog steps are
// selected by ARB_TIMEOUT_EN to match the build of the design.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        inst_ren;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        inst_stall;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        data_stall;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;
    logic        arb_err;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .inst_ren  (inst_ren),
        .inst_addr (inst_addr),
        .inst_data (inst_data),
        .inst_stall(inst_stall),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .data_stall(data_stall),
        .ram_req   (ram_req),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ack   (ram_ack),
        .arb_err   (arb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL tb_time_limit observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [31:0] alt_addr [4];

    initial begin
        rst_n     = 1'b0;
        inst_ren  = 1'b0;
        inst_addr = '0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_dout  = '0;
        ram_rdata = '0;
        ram_ack   = 1'b0;
        alt_addr  = '{32'h300, 32'h80, 32'h300, 32'h80};

        // Reset state
        tick();
        tick();
        check("rst_ram_req", {31'd0, ram_req}, 32'd0);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        check("rst_inst_data", inst_data, 32'd0);
        check("rst_mem_din", mem_din, 32'd0);
        check("rst_arb_err", {31'd0, arb_err}, 32'd0);
        rst_n = 1'b1;

        // Single fetch, ack during the first ram_req cycle
        tick();
        inst_ren  = 1'b1;
        inst_addr = 32'h0000_0010;
        settle();
        check("f_c0_stall", {31'd0, inst_stall}, 32'd1);
        check("f_c0_req", {31'd0, ram_req}, 32'd0);
        tick();
        settle();
        check("f_c1_req", {31'd0, ram_req}, 32'd1);
        check("f_c1_addr", ram_addr, 32'h10);
        check("f_c1_we", {31'd0, ram_we}, 32'd0);
        check("f_c1_stall", {31'd0, inst_stall}, 32'd1);
        ram_ack   = 1'b1;
        ram_rdata = 32'h2008_0005;
        tick();
        ram_ack   = 1'b0;
        ram_rdata = '0;
        settle();
        check("f_c2_stall", {31'd0, inst_stall}, 32'd0);
        check("f_c2_req", {31'd0, ram_req}, 32'd0);
        check("f_c2_data", inst_data, 32'h2008_0005);
        inst_ren = 1'b0;

        // Fresh reset so last_grant is back at I, then simultaneous requests
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        inst_ren  = 1'b1;
        inst_addr = 32'h40;
        mem_ren   = 1'b1;
        mem_addr  = 32'h200;
        settle();
        check("c_c0_istall", {31'd0, inst_stall}, 32'd1);
        check("c_c0_dstall", {31'd0, data_stall}, 32'd1);
        tick();
        settle();
        check("c_c1_req", {31'd0, ram_req}, 32'd1);
        check("c_c1_addr_data_first", ram_addr, 32'h200);
        ram_ack   = 1'b1;
        ram_rdata = 32'h1111_1111;
        tick();
        ram_ack = 1'b0;
        mem_ren = 1'b0;
        settle();
        check("c_c2_dstall", {31'd0, data_stall}, 32'd0);
        check("c_c2_istall", {31'd0, inst_stall}, 32'd1);
        check("c_c2_mem_din", mem_din, 32'h1111_1111);
        tick();
        settle();
        check("c_c3_req", {31'd0, ram_req}, 32'd1);
        check("c_c3_addr_fetch", ram_addr, 32'h40);
        ram_ack   = 1'b1;
        ram_rdata = 32'h2222_2222;
        tick();
        ram_ack = 1'b0;
        settle();
        check("c_c4_istall", {31'd0, inst_stall}, 32'd0);
        check("c_c4_inst_data", inst_data, 32'h2222_2222);
        inst_ren = 1'b0;

        // Four back-to-back conflicting transactions alternate D, I, D, I
        tick();
        inst_ren  = 1'b1;
        inst_addr = 32'h80;
        mem_ren   = 1'b1;
        mem_addr  = 32'h300;
        settle();
        for (int k = 0; k < 4; k++) begin
            tick();
            settle();
            check("alt_req", {31'd0, ram_req}, 32'd1);
            check("alt_addr", ram_addr, alt_addr[k]);
            ram_ack   = 1'b1;
            ram_rdata = 32'hA000_0000 + 32'(k);
            tick();
            ram_ack = 1'b0;
            settle();
            if (k % 2 == 0) begin
                check("alt_d_dstall", {31'd0, data_stall}, 32'd0);
                check("alt_d_istall", {31'd0, inst_stall}, 32'd1);
                check("alt_d_mem_din", mem_din, 32'hA000_0000 + 32'(k));
            end else begin
                check("alt_i_istall", {31'd0, inst_stall}, 32'd0);
                check("alt_i_dstall", {31'd0, data_stall}, 32'd1);
                check("alt_i_inst_data", inst_data, 32'hA000_0000 + 32'(k));
            end
        end
        inst_ren = 1'b0;
        mem_ren  = 1'b0;

        // Read+write together is a write; mem_din keeps the last read value
        tick();
        mem_ren  = 1'b1;
        mem_wen  = 1'b1;
        mem_addr = 32'h100;
        mem_dout = 32'hCAFE_F00D;
        settle();
        check("w_c0_dstall", {31'd0, data_stall}, 32'd1);
        tick();
        settle();
        check("w_c1_req", {31'd0, ram_req}, 32'd1);
        check("w_c1_we", {31'd0, ram_we}, 32'd1);
        check("w_c1_addr", ram_addr, 32'h100);
        check("w_c1_wdata", ram_wdata, 32'hCAFE_F00D);
        mem_addr  = 32'h104;
        mem_dout  = 32'h0;
        ram_ack   = 1'b1;
        ram_rdata = 32'h5555_5555;
        settle();
        check("w_c1_addr_latched", ram_addr, 32'h100);
        check("w_c1_wdata_latched", ram_wdata, 32'hCAFE_F00D);
        tick();
        ram_ack = 1'b0;
        settle();
        check("w_c2_dstall", {31'd0, data_stall}, 32'd0);
        check("w_c2_req", {31'd0, ram_req}, 32'd0);
        check("w_c2_mem_din_kept", mem_din, 32'hA000_0002);
        mem_ren = 1'b0;
        mem_wen = 1'b0;

        // Reset while GNT_D waits for ack, then a late ack in IDLE
        tick();
        mem_ren  = 1'b1;
        mem_addr = 32'h500;
        settle();
        tick();
        settle();
        check("r_c1_req", {31'd0, ram_req}, 32'd1);
        check("r_c1_addr", ram_addr, 32'h500);
        tick();
        settle();
        check("r_c2_req_wait", {31'd0, ram_req}, 32'd1);
        rst_n = 1'b0;
        settle();
        check("r_req_drop", {31'd0, ram_req}, 32'd0);
        check("r_mem_din_clr", mem_din, 32'd0);
        mem_ren = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        tick();
        ram_ack   = 1'b1;
        ram_rdata = 32'h7777_7777;
        mem_ren   = 1'b1;
        mem_addr  = 32'h504;
        settle();
        check("r_late_dstall", {31'd0, data_stall}, 32'd1);
        check("r_late_req", {31'd0, ram_req}, 32'd0);
        tick();
        ram_ack = 1'b0;
        settle();
        check("r_no_done_dstall", {31'd0, data_stall}, 32'd1);
        check("r_new_req", {31'd0, ram_req}, 32'd1);
        check("r_new_addr", ram_addr, 32'h504);
        check("r_late_ignored", mem_din, 32'd0);
        ram_ack   = 1'b1;
        ram_rdata = 32'h1234_5678;
        tick();
        ram_ack = 1'b0;
        settle();
        check("r_done_dstall", {31'd0, data_stall}, 32'd0);
        check("r_done_mem_din", mem_din, 32'h1234_5678);
        mem_ren = 1'b0;

        // Transaction with no ack at all
        tick();
        mem_ren  = 1'b1;
        mem_addr = 32'h600;
        settle();
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            tick();
            settle();
            check("to_wait_req", {31'd0, ram_req}, 32'd1);
        end
        tick();
        settle();
        check("to_abort_req", {31'd0, ram_req}, 32'd0);
        check("to_abort_dstall", {31'd0, data_stall}, 32'd0);
        check("to_dead_word", mem_din, 32'hDEAD_BEEF);
        check("to_arb_err", {31'd0, arb_err}, 32'd1);
        mem_ren = 1'b0;
        tick();
        tick();
        tick();
        check("to_arb_err_sticky", {31'd0, arb_err}, 32'd1);
`else
        for (int c = 0; c < 6; c++) begin
            tick();
            settle();
            check("nt_wait_req", {31'd0, ram_req}, 32'd1);
            check("nt_wait_dstall", {31'd0, data_stall}, 32'd1);
        end
        check("nt_arb_err", {31'd0, arb_err}, 32'd0);
        ram_ack   = 1'b1;
        ram_rdata = 32'h0BAD_F00D;
        tick();
        ram_ack = 1'b0;
        settle();
        check("nt_done_dstall", {31'd0, data_stall}, 32'd0);
        check("nt_mem_din", mem_din, 32'h0BAD_F00D);
        mem_ren = 1'b0;
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between the core's instruction-fetch port (inst_*) and data port (mem_*).
- Sits between mips_core and the unified RAM.
- Converts the core's level-type read/write enables into a registered req/ack transaction on the RAM side.
- Returns per-port stall signals so the pipeline holds until its access completes.

Parameters:
- ADDR_W, 32, address width of both core ports and the RAM port.
- DATA_W, 32, data width.
- TIMEOUT, 255, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  main clock
- rst  in  1  asynchronous, active-low reset
- inst_ren  in  1  fetch request from core
- inst_addr  in  ADDR_W  fetch address
- inst_data  out  DATA_W  fetched word, held until next fetch completes
- inst_stall  out  1  fetch not yet complete
- mem_ren  in  1  data read request
- mem_wen  in  1  data write request
- mem_addr  in  ADDR_W  data address
- mem_dout  in  DATA_W  write data from core
- mem_din  out  DATA_W  read data to core, held until next data read completes
- data_stall  out  1  data access not yet complete
- ram_req  out  1  RAM transaction valid
- ram_we  out  1  RAM write
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid with ram_ack
- ram_ack  in  1  RAM completion, one-cycle pulse
- arb_err  out  1  sticky timeout flag; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - ram_req, ram_we, arb_err, i_done, d_done, last_grant all go to 0.
  - ram_addr, ram_wdata, inst_data, mem_din all go to 0.
  - Reset mid-transaction drops ram_req immediately and discards the access; any late ram_ack in IDLE is ignored.
- States and transitions:
  - IDLE -> GNT_D or GNT_I on the next edge when a request is pending. Transaction fields are latched: addr/wdata/we (data: we = mem_wen).
  - GNT_x holds ram_req=1 with stable fields until ram_ack is sampled high. Then: ram_req goes to 0, read data is latched to inst_data/mem_din (reads only), x_done pulses 1 for one cycle, and state returns to IDLE.
- Stall rules:
  - inst_stall = inst_ren & ~i_done.
  - data_stall = (mem_ren|mem_wen) & ~d_done.
  - Both are combinational from registered done flags. A done flag is high for exactly one cycle.
- Latency: request seen in cycle 0; ram_req high from cycle 1; with ack in cycle 1, done and stall-low occur in cycle 2. Each extra ack-wait cycle adds 1.
- Arbitration when both ports request in IDLE:
  - If last_grant=I, data wins.
  - If last_grant=D, instruction wins.
  - last_grant updates at every grant. This prevents starvation.
- Port behaviour:
  - A request is never granted in the cycle its done flag is high; it is treated as serviced.
  - mem_ren & mem_wen together: the access is a write.
  - Writes do not modify mem_din.
  - Core inputs may change while stalled; latched fields are used.
  - ram_ack outside GNT_x is ignored.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - An 8-bit wait counter runs in GNT_x.
  - Reaching TIMEOUT without ram_ack aborts the transaction: ram_req goes to 0, the read result is DEAD_WORD (32'hDEADBEEF), the done pulse is issued, and arb_err is set sticky until reset.
  - The counter clears on every grant.
- ARB_TIMEOUT_EN undefined: no counter, GNT_x waits indefinitely, arb_err tied 0.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, GNT_I, GNT_D)
  - grant-id encoding (GRANT_I=0, GRANT_D=1)
  - DEAD_WORD constant
  - default TIMEOUT
- Sub-module mem_arb_watchdog (counter + expiry compare) is instantiated only under ARB_TIMEOUT_EN.

Test Plan:
- Reset, then inst_ren=1, addr=0x0000_0010; RAM acks the cycle after ram_req with 0x2008_0005 -> inst_stall high 2 cycles; inst_data=0x2008_0005 in cycle 2.
- inst_ren and mem_ren both high after reset (last_grant=0) -> data granted first (ram_addr=mem_addr); fetch granted next; data_stall drops 2 cycles before inst_stall.
- Back-to-back conflicting requests over 4 transactions -> grants alternate D, I, D, I.
- mem_wen=1 with mem_ren=1, addr=0x100, dout=0xCAFE_F00D -> ram_we=1, ram_wdata=0xCAFE_F00D; mem_din unchanged.
- Assert rst low while in GNT_D waiting for ack -> ram_req drops the same cycle; after release, FSM is in IDLE and a late ram_ack causes no done pulse.
- With ARB_TIMEOUT_EN, TIMEOUT=4, no ram_ack -> abort after 4 wait cycles; mem_din=0xDEADBEEF; arb_err=1 and stays set.
